// File: rtl/immgen_pipe.sv
// ============================================================================
// Module   : immgen_pipe
// Purpose  : RV32I/RVC immediate generator with output register + skid buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

module immgen_pipe #(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            is_c_o,
  output logic            illegal_o
);

  localparam logic [2:0] c_FMT_R   = 3'd0;
  localparam logic [2:0] c_FMT_I   = 3'd1;
  localparam logic [2:0] c_FMT_S   = 3'd2;
  localparam logic [2:0] c_FMT_B   = 3'd3;
  localparam logic [2:0] c_FMT_U   = 3'd4;
  localparam logic [2:0] c_FMT_J   = 3'd5;
  localparam logic [2:0] c_FMT_C   = 3'd6;
  localparam logic [2:0] c_FMT_ILL = 3'd7;
  localparam int         c_DW      = XLEN + 5;

  // State bit 1 = OUT valid, bit 0 = SKID valid.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  logic [31:0]     w_imm32;
  logic [2:0]      w_fmt;
  logic            w_is_c;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;
  logic [c_DW-1:0] w_dec;

  always_comb begin
    w_imm32   = '0;
    w_fmt     = c_FMT_R;
    w_illegal = 1'b0;
    w_is_c    = (instr_i[1:0] != 2'b11);
    if (!w_is_c) begin
      case (instr_i[6:0])
        7'b0110011: w_fmt = c_FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111: begin
          w_fmt   = c_FMT_I;
          w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        end
        7'b0100011: begin
          w_fmt   = c_FMT_S;
          w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end
        7'b1100011: begin
          w_fmt   = c_FMT_B;
          w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          w_fmt   = c_FMT_U;
          w_imm32 = {instr_i[31:12], 12'b0};
        end
        7'b1101111: begin
          w_fmt   = c_FMT_J;
          w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
        end
        default: w_illegal = 1'b1;
      endcase
    end else if (!RVC_EN) begin
      w_illegal = 1'b1;
    end else begin
      w_fmt = c_FMT_C;
      // Index is {quadrant, funct3}; all-zero halfword falls into the default.
      case ({instr_i[1:0], instr_i[15:13]})
        5'b01_000, 5'b01_010:
          w_imm32 = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
        5'b01_001, 5'b01_101:
          w_imm32 = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9],
                     instr_i[6], instr_i[7], instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
        5'b01_110, 5'b01_111:
          w_imm32 = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                     instr_i[11:10], instr_i[4:3], 1'b0};
        5'b00_010, 5'b00_110:
          w_imm32 = {25'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b0};
        5'b10_010:
          w_imm32 = {24'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b0};
        5'b10_110:
          w_imm32 = {24'b0, instr_i[8:7], instr_i[12:9], 2'b0};
        5'b10_100:
          w_imm32 = '0;
        default: w_illegal = 1'b1;
      endcase
    end
    if (w_illegal) begin
      w_imm32 = '0;
      w_fmt   = c_FMT_ILL;
    end
  end

  generate
    if (XLEN > 32) begin : g_sext_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_sext_narrow
      assign w_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

  assign w_dec = {w_imm, w_fmt, w_is_c, w_illegal};

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ready;
  logic [c_DW-1:0] r_out_data;
  logic [c_DW-1:0] r_skid_data;
  logic            w_drain;
  logic            w_accept;
  logic            w_load_out;
  logic            w_out_from_skid;
  logic            w_load_skid;

  assign w_drain  = r_state[1] && ready_i;
  assign w_accept = valid_i && r_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else if (w_drain && r_state[0]) begin
      w_state_nxt     = S_ONE;
      w_load_out      = 1'b1;
      w_out_from_skid = 1'b1;
    end else if (w_accept) begin
      if (!r_state[1] || w_drain) begin
        w_state_nxt = S_ONE;
        w_load_out  = 1'b1;
      end else begin
        w_state_nxt = S_FULL;
        w_load_skid = 1'b1;
      end
    end else if (w_drain) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= !w_state_nxt[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_out) r_out_data <= w_out_from_skid ? r_skid_data : w_dec;
      if (w_load_skid) r_skid_data <= w_dec;
    end
  end

  assign ready_o   = r_ready;
  assign valid_o   = r_state[1];
  assign imm_o     = r_out_data[c_DW-1:5];
  assign fmt_o     = r_out_data[4:2];
  assign is_c_o    = r_out_data[1];
  assign illegal_o = r_out_data[0];

endmodule

`default_nettype wire
